// File: rtl/fifo_pkg.sv
// Shared definitions for the per-virtual-channel FIFO and the transaction-layer
// control FSM that consumes its empty bit and drives its thresholds.
package fifo_pkg;

  // Default geometry: eight 6-bit words, addressed by a 3-bit pointer so that
  // the FSM's 3-bit Umbral thresholds span the whole occupancy range.
  localparam int DATA_W_DEF = 6;
  localparam int DEPTH_DEF  = 8;
  localparam int PTR_W_DEF  = 3;

  // Control FSM state encodings (one-hot), kept here so the FSM and any
  // top-level environment agree on them.
  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } fsm_state_e;

  // Occupancy-derived status bits of one FIFO, grouped so they can be
  // observed or forwarded as a single bundle.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage with one synchronous write port and one synchronous
// read port. The array itself is never reset; only the read register is, so
// the read data presented downstream is a known zero out of reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port: store the word at the write address on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: capture the addressed word on an accepted pop. A write to the
  // same address in the same cycle lands after this read, so the old word
  // (the one being popped) is returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : fifo_mem

// File: rtl/fifo_umbral.sv
// Synchronous FIFO for one virtual channel. Tracks occupancy, produces the
// empty bit that feeds the control FSM's Empties vector, and compares the
// occupancy against the FSM's programmable almost-full / almost-empty
// thresholds.
//
// Handshake: a push is accepted when push is high and the FIFO is not full,
// or when a pop is accepted in the same cycle; a pop is accepted when pop is
// high and the FIFO is not empty (no empty bypass). Accepted pops return
// their word on data_out one cycle later, qualified by valid_out. Push into a
// full FIFO without a pop, or pop from an empty FIFO, sets the sticky error.
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic [PTR_W-1:0]  umbral_superior,
  input  logic [PTR_W-1:0]  umbral_inferior,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PTR_W:0]    count,
  output logic              error
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             valid_q,  valid_d;
  logic             error_q,  error_d;

  logic             push_acc;
  logic             pop_acc;
  fifo_flags_t      flags;

  // Status flags are pure functions of the registered occupancy and the live
  // thresholds, so a threshold change is reflected in the same cycle.
  always_comb begin
    flags              = '0;
    flags.empty        = (count_q == '0);
    flags.full         = (count_q == DEPTH_C);
    flags.almost_full  = (count_q >= {1'b0, umbral_superior});
    flags.almost_empty = (count_q <= {1'b0, umbral_inferior});
  end

  // Acceptance: a pop frees a slot in the same cycle, so a full FIFO can
  // still take a push alongside it; an empty FIFO never forwards a push.
  always_comb begin
    pop_acc  = pop && !flags.empty;
    push_acc = push && (!flags.full || pop_acc);
  end

  // Next-state for pointers, occupancy, read-valid and the sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = pop_acc;
    error_d  = error_q;

    // Pointers wrap through natural PTR_W-bit overflow.
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Overflow drops the word; underflow returns nothing. Both stick.
    if (push && flags.full && !pop_acc) begin
      error_d = 1'b1;
    end
    if (pop && flags.empty) begin
      error_d = 1'b1;
    end
  end

  // Control state registers, cleared asynchronously so in-flight words and
  // the read-valid are discarded the moment reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset),
    .we    (push_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (pop_acc),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  assign valid_out    = valid_q;
  assign count        = count_q;
  assign error        = error_q;
  assign empty        = flags.empty;
  assign full         = flags.full;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;

endmodule : fifo_umbral

// File: tb/tb_fifo_umbral.sv
// Randomised, scoreboarded bench for fifo_umbral. A queue-based reference
// model predicts occupancy, flags, error and the popped data stream; a
// separate monitor compares every valid_out beat against the expected queue.
module tb_fifo_umbral;

  localparam int DW = 6;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          push, pop;
  logic [DW-1:0] data_in;
  logic [2:0]    us, ui;
  logic [DW-1:0] data_out;
  logic          valid_out, empty, full, almost_full, almost_empty, error;
  logic [3:0]    count;

  always #5 clk = ~clk;

  fifo_umbral dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .data_in         (data_in),
    .pop             (pop),
    .umbral_superior (us),
    .umbral_inferior (ui),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .empty           (empty),
    .full            (full),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .count           (count),
    .error           (error)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] mq[$];      // words currently held by the FIFO
  logic [DW-1:0] exp_q[$];   // words expected on data_out, in order
  bit            m_err;
  bit            exp_vld;    // a pop was accepted in the cycle before the next edge
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_flags(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".count"}, int'(count), n);
    chk({tag, ".empty"}, int'(empty), int'(n == 0));
    chk({tag, ".full"}, int'(full), int'(n == 8));
    chk({tag, ".almost_full"}, int'(almost_full), int'(n >= int'(us)));
    chk({tag, ".almost_empty"}, int'(almost_empty), int'(n <= int'(ui)));
    chk({tag, ".error"}, int'(error), int'(m_err));
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_err   = 1'b0;
    exp_vld = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle of stimulus: drive at the falling edge, check the
  // combinational view, then advance the model to what the next edge does.
  task automatic step(input string tag, input bit p, input logic [DW-1:0] d, input bit po);
    int n;
    bit pa, qa;
    @(negedge clk);
    push    = p;
    data_in = d;
    pop     = po;
    #1;
    check_flags(tag);
    n  = mq.size();
    qa = po && (n > 0);
    pa = p && ((n < 8) || qa);
    if (p && (n == 8) && !qa) m_err = 1'b1;
    if (po && (n == 0))       m_err = 1'b1;
    if (qa) exp_q.push_back(mq.pop_front());
    if (pa) mq.push_back(d);
    exp_vld = qa;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    model_clear();
    #1;
    check_flags("in_reset");
    chk("in_reset.valid_out", int'(valid_out), 0);
    chk("in_reset.data_out", int'(data_out), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always begin
    bit v;
    @(posedge clk);
    v = exp_vld;
    #1;
    chk("valid_out", int'(valid_out), int'(v));
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_out unexpected word actual=%0d expected=none at %0t", data_out, $time);
      end else begin
        chk("data_out", int'(data_out), int'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    us      = 3'd6;
    ui      = 3'd2;
    model_clear();

    // Reset then idle.
    do_reset();
    step("idle", 0, 0, 0);
    step("idle", 0, 0, 0);

    // Fill 0x01..0x08, then drain in order.
    for (int i = 1; i <= 8; i++) step("fill", 1, DW'(i), 0);
    for (int i = 0; i < 8; i++) step("drain", 0, 0, 1);
    step("drained", 0, 0, 0);
    step("drained", 0, 0, 0);

    // Preload 5, then 10 cycles of simultaneous push/pop (pointers wrap).
    for (int i = 0; i < 5; i++) step("preload", 1, DW'($urandom_range(0, 63)), 0);
    for (int i = 0; i < 10; i++) step("pushpop", 1, DW'($urandom_range(0, 63)), 1);

    // Top up to full, push 0x2A together with a pop, then drain 8.
    for (int i = 0; i < 3; i++) step("topup", 1, DW'($urandom_range(0, 63)), 0);
    step("full_pushpop", 1, 6'h2A, 1);
    for (int i = 0; i < 8; i++) step("drain2", 0, 0, 1);
    step("drained2", 0, 0, 0);

    // Overflow: push into a full FIFO without a pop; dropped word must not appear.
    for (int i = 0; i < 8; i++) step("fill3", 1, DW'(i + 32), 0);
    step("overflow", 1, 6'h3F, 0);
    step("after_ovf", 0, 0, 0);
    for (int i = 0; i < 8; i++) step("drain3", 0, 0, 1);
    step("drained3", 0, 0, 0);

    // Empty with push and pop together: push taken, pop rejected, error set.
    do_reset();
    step("empty_pushpop", 1, 6'h15, 1);
    step("after_epp", 0, 0, 0);
    step("pop_one", 0, 0, 1);
    step("after_pop", 0, 0, 0);

    // Underflow after reset, then reset mid-stream with count 4.
    do_reset();
    step("underflow", 0, 0, 1);
    step("after_udf", 0, 0, 0);
    for (int i = 0; i < 5; i++) step("mid_fill", 1, DW'(i + 7), 0);
    step("mid_pop", 0, 0, 1);
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
    #1;
    chk("pre_reset.count", int'(count), 4);
    chk("pre_reset.valid_out", int'(valid_out), 1);
    chk("pre_reset.error", int'(error), 1);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    chk("async_reset.count", int'(count), 0);
    chk("async_reset.valid_out", int'(valid_out), 0);
    chk("async_reset.error", int'(error), 0);
    check_flags("async_reset");
    @(negedge clk);
    reset = 1'b1;
    step("post_push", 1, 6'h11, 0);
    step("post_pop", 0, 0, 1);
    step("post_idle", 0, 0, 0);

    // Threshold corner values on an empty FIFO.
    us = 3'd0;
    ui = 3'd7;
    step("thr_corner", 0, 0, 0);
    for (int i = 0; i < 8; i++) step("thr_fill", 1, DW'(i), 0);
    for (int i = 0; i < 8; i++) step("thr_drain", 0, 0, 1);

    // Randomised traffic with random thresholds, fill-biased then drain-biased.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i % 100 < 50) ? 70 : 30;
      us = 3'($urandom_range(0, 7));
      ui = 3'($urandom_range(0, 7));
      step("random",
           $urandom_range(0, 99) < bias,
           DW'($urandom_range(0, 63)),
           $urandom_range(0, 99) >= bias);
    end

    step("final", 0, 0, 0);
    step("final", 0, 0, 0);
    chk("leftover_expected", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_umbral
